cc_lives_controller: RTL and testbench



---
 rtl/cc_lives_pkg.sv | 15 +
 rtl/cc_lives_controller_if.sv | 35 +++
 rtl/cc_hold_timer.sv | 23 ++
 rtl/cc_lives_controller.sv | 115 +++++++++++
 tb/tb_cc_lives_controller.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cc_lives_pkg.sv
// Shared state encoding and default game constants for the Frogger lives controller.
package cc_lives_pkg;

    typedef logic [2:0] cc_state_t;

    localparam cc_state_t ST_IDLE     = 3'd0;
    localparam cc_state_t ST_RESPAWN  = 3'd1;
    localparam cc_state_t ST_PLAY     = 3'd2;
    localparam cc_state_t ST_DYING    = 3'd3;
    localparam cc_state_t ST_GAMEOVER = 3'd4;

    localparam int DEFAULT_INIT_LIVES        = 3;
    localparam int DEFAULT_DEATH_HOLD_CYCLES = 100;

endpackage

// File: rtl/cc_lives_controller_if.sv
// Event inputs and status outputs of the lives controller, bundled for the playfield side.
interface cc_lives_controller_if #(
    parameter int W = 3
);
    logic         CC_LIVES_CONTROLLER_start_InHigh;
    logic         CC_LIVES_CONTROLLER_death_InHigh;
    logic         CC_LIVES_CONTROLLER_goal_InHigh;
    logic [W-1:0] CC_LIVES_CONTROLLER_lives_Out;
    logic         CC_LIVES_CONTROLLER_alive_OutHigh;
    logic         CC_LIVES_CONTROLLER_respawn_OutHigh;
    logic         CC_LIVES_CONTROLLER_freeze_OutHigh;
    logic         CC_LIVES_CONTROLLER_gameover_OutHigh;

    modport master (
        output CC_LIVES_CONTROLLER_start_InHigh,
        output CC_LIVES_CONTROLLER_death_InHigh,
        output CC_LIVES_CONTROLLER_goal_InHigh,
        input  CC_LIVES_CONTROLLER_lives_Out,
        input  CC_LIVES_CONTROLLER_alive_OutHigh,
        input  CC_LIVES_CONTROLLER_respawn_OutHigh,
        input  CC_LIVES_CONTROLLER_freeze_OutHigh,
        input  CC_LIVES_CONTROLLER_gameover_OutHigh
    );

    modport slave (
        input  CC_LIVES_CONTROLLER_start_InHigh,
        input  CC_LIVES_CONTROLLER_death_InHigh,
        input  CC_LIVES_CONTROLLER_goal_InHigh,
        output CC_LIVES_CONTROLLER_lives_Out,
        output CC_LIVES_CONTROLLER_alive_OutHigh,
        output CC_LIVES_CONTROLLER_respawn_OutHigh,
        output CC_LIVES_CONTROLLER_freeze_OutHigh,
        output CC_LIVES_CONTROLLER_gameover_OutHigh
    );
endinterface

// File: rtl/cc_hold_timer.sv
// Clearable up-counter that flags the last cycle of the post-death hold.
module cc_hold_timer #(
    parameter int HOLD_WIDTH        = 8,
    parameter int DEATH_HOLD_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);
    logic [HOLD_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = clear ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign tc = (count_q == HOLD_WIDTH'(DEATH_HOLD_CYCLES - 1));
endmodule

// File: rtl/cc_lives_controller.sv
// Frogger life-count and death/respawn sequencer; goal extra-life enabled by CC_LIVES_CONTROLLER_EXTRA_LIFE_EN.
// state    | meaning
// IDLE     | waiting for first start, lives preset, play frozen
// RESPAWN  | one-cycle frog reset pulse, lives reloaded when coming from IDLE/GAMEOVER
// PLAY     | gameplay running, deaths (and optionally goals) update lives
// DYING    | frozen hold after a death, events ignored
// GAMEOVER | no lives left, waiting for start
module cc_lives_controller
    import cc_lives_pkg::*;
#(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int INIT_LIVES              = DEFAULT_INIT_LIVES,
    parameter int HOLD_WIDTH              = 8,
    parameter int DEATH_HOLD_CYCLES       = DEFAULT_DEATH_HOLD_CYCLES
) (
    input  logic                  CC_LIVES_CONTROLLER_CLOCK_50,
    input  logic                  CC_LIVES_CONTROLLER_RESET_InHigh,
    cc_lives_controller_if.slave  bus
);
    localparam int W = LIVES_COUNTER_DATAWIDTH;
    localparam logic [W-1:0] LIVES_INIT = W'(INIT_LIVES);
    localparam logic [W-1:0] LIVES_MAX  = '1;

    logic         clk, rst;
    logic         start, death;
    cc_state_t    state_q, state_d;
    logic [W-1:0] lives_q, lives_d;
    logic         respawn_q, respawn_d;
    logic         freeze_q, freeze_d;
    logic         gameover_q, gameover_d;
    logic         hold_tc;

    assign clk   = CC_LIVES_CONTROLLER_CLOCK_50;
    assign rst   = CC_LIVES_CONTROLLER_RESET_InHigh;
    assign start = bus.CC_LIVES_CONTROLLER_start_InHigh;
    assign death = bus.CC_LIVES_CONTROLLER_death_InHigh;

    cc_hold_timer #(
        .HOLD_WIDTH        (HOLD_WIDTH),
        .DEATH_HOLD_CYCLES (DEATH_HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q != ST_DYING),
        .tc    (hold_tc)
    );

`ifndef CC_LIVES_CONTROLLER_EXTRA_LIFE_EN
    logic unused_goal;
    assign unused_goal = bus.CC_LIVES_CONTROLLER_goal_InHigh;
`endif

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ST_IDLE: begin
                lives_d = LIVES_INIT;
                if (start) state_d = ST_RESPAWN;
            end
            ST_RESPAWN: state_d = ST_PLAY;
            ST_PLAY: begin
                if (death) begin
                    state_d = ST_DYING;
                    lives_d = (lives_q == '0) ? '0 : lives_q - 1'b1;
                end
`ifdef CC_LIVES_CONTROLLER_EXTRA_LIFE_EN
                else if (bus.CC_LIVES_CONTROLLER_goal_InHigh) begin
                    lives_d = (lives_q == LIVES_MAX) ? LIVES_MAX : lives_q + 1'b1;
                end
`endif
            end
            ST_DYING: begin
                if (hold_tc) state_d = (lives_q == '0) ? ST_GAMEOVER : ST_RESPAWN;
            end
            ST_GAMEOVER: begin
                lives_d = '0;
                if (start) begin
                    state_d = ST_RESPAWN;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lives_d = LIVES_INIT;
            end
        endcase
        // Outputs are registered from the next state so they align with it.
        respawn_d  = (state_d == ST_RESPAWN);
        freeze_d   = (state_d != ST_PLAY);
        gameover_d = (state_d == ST_GAMEOVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lives_q    <= LIVES_INIT;
            respawn_q  <= 1'b0;
            freeze_q   <= 1'b1;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            respawn_q  <= respawn_d;
            freeze_q   <= freeze_d;
            gameover_q <= gameover_d;
        end
    end

    assign bus.CC_LIVES_CONTROLLER_lives_Out        = lives_q;
    assign bus.CC_LIVES_CONTROLLER_alive_OutHigh    = (lives_q != '0);
    assign bus.CC_LIVES_CONTROLLER_respawn_OutHigh  = respawn_q;
    assign bus.CC_LIVES_CONTROLLER_freeze_OutHigh   = freeze_q;
    assign bus.CC_LIVES_CONTROLLER_gameover_OutHigh = gameover_q;
endmodule

// File: tb/tb_cc_lives_controller.sv
// Directed bench for cc_lives_controller with W=3, INIT_LIVES=3, DEATH_HOLD_CYCLES=4.
module tb_cc_lives_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_lives;

    always #5 clk = ~clk;

    cc_lives_controller_if #(.W(3)) bus ();

    cc_lives_controller #(
        .LIVES_COUNTER_DATAWIDTH (3),
        .INIT_LIVES              (3),
        .HOLD_WIDTH              (8),
        .DEATH_HOLD_CYCLES       (4)
    ) dut (
        .CC_LIVES_CONTROLLER_CLOCK_50     (clk),
        .CC_LIVES_CONTROLLER_RESET_InHigh (rst),
        .bus                              (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int lives, input int respawn,
                           input int freeze, input int gameover);
        chk({tag, ".lives"},    int'(bus.CC_LIVES_CONTROLLER_lives_Out), lives);
        chk({tag, ".alive"},    int'(bus.CC_LIVES_CONTROLLER_alive_OutHigh), (lives != 0) ? 1 : 0);
        chk({tag, ".respawn"},  int'(bus.CC_LIVES_CONTROLLER_respawn_OutHigh), respawn);
        chk({tag, ".freeze"},   int'(bus.CC_LIVES_CONTROLLER_freeze_OutHigh), freeze);
        chk({tag, ".gameover"}, int'(bus.CC_LIVES_CONTROLLER_gameover_OutHigh), gameover);
    endtask

    // Death pulse in PLAY, then the 4-cycle hold; ends in the cycle after the hold.
    task automatic die(input string tag, input int lives_after);
        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b0;
        chk_out({tag, ".hold1"}, lives_after, 0, 1, 0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk_out({tag, ".hold"}, lives_after, 0, 1, 0);
        end
        step();
    endtask

    initial begin
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b0;
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b0;

        step();
        step();
        rst = 1'b0;
        chk_out("reset", 3, 0, 1, 0);

        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        chk_out("start.respawn", 3, 1, 1, 0);
        step();
        chk_out("start.play", 3, 0, 0, 0);

        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        chk_out("play.start_ignored", 3, 0, 0, 0);

        die("death1", 2);
        chk_out("death1.respawn", 2, 1, 1, 0);
        step();
        chk_out("death1.play", 2, 0, 0, 0);

        die("death2", 1);
        chk_out("death2.respawn", 1, 1, 1, 0);
        step();
        chk_out("death2.play", 1, 0, 0, 0);

        die("death3", 0);
        chk_out("death3.gameover", 0, 0, 1, 1);
        step();
        step();
        chk_out("gameover.stay", 0, 0, 1, 1);

        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        chk_out("restart.respawn", 3, 1, 1, 0);
        step();
        chk_out("restart.play", 3, 0, 0, 0);

        die("to_two", 2);
        step();
        chk_out("to_two.play", 2, 0, 0, 0);

        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b1;
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b0;
        chk_out("coincide.hold1", 1, 0, 1, 0);
        step();
        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b0;
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b1;
        chk_out("coincide.hold2", 1, 0, 1, 0);
        step();
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b0;
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b1;
        chk_out("coincide.hold3", 1, 0, 1, 0);
        step();
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        chk_out("coincide.hold4", 1, 0, 1, 0);
        step();
        chk_out("coincide.respawn", 1, 1, 1, 0);
        step();
        chk_out("coincide.play", 1, 0, 0, 0);

        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_death_InHigh = 1'b0;
        chk_out("midreset.hold1", 0, 0, 1, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("midreset.idle", 3, 0, 1, 0);
        step();
        chk_out("midreset.idle2", 3, 0, 1, 0);

        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b1;
        step();
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        step();
        chk_out("goals.play", 3, 0, 0, 0);
        exp_lives = 3;
        for (int g = 0; g < 6; g++) begin
            bus.CC_LIVES_CONTROLLER_goal_InHigh = 1'b1;
            step();
            bus.CC_LIVES_CONTROLLER_goal_InHigh = 1'b0;
`ifdef CC_LIVES_CONTROLLER_EXTRA_LIFE_EN
            if (exp_lives < 7) exp_lives++;
`endif
            chk("goal.lives", int'(bus.CC_LIVES_CONTROLLER_lives_Out), exp_lives);
            step();
        end
`ifdef CC_LIVES_CONTROLLER_EXTRA_LIFE_EN
        chk_out("goals.final", 7, 0, 0, 0);
`else
        chk_out("goals.final", 3, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
